// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter -- shares one buzzer tone generator between the horn, the
// reverse-gear beeper and the turn-signal ticker.
//
// Fixed priority horn > reverse > tick.  A horn press preempts anything at
// once.  Reverse beeps with alternating BEEP_ON-cycle tone and BEEP_OFF-cycle
// silence.  A turn tick is queued by a blinker toggle and plays for TICK_LEN
// cycles once nothing with higher priority wants the buzzer.
//
// Optional feature macro: BUZZER_TICK_EN.  When it is defined, the tick path is
// built in.  When it is undefined, turn_req and turn_blink are ignored and
// grant[2] is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   horn_req   in   level, horn key held
//   rev_req    in   level, reverse gear engaged
//   turn_req   in   level, a turn signal is active
//   turn_blink in   one-cycle pulse on each blinker toggle
//   note_div   out  [21:0] tone divider for the buzzer generator, 0 = silent
//   grant      out  [2:0] one-hot owner {tick, rev, horn}, 0 when idle
//   busy       out  high whenever grant is non-zero
module buzzer_arbiter #(
  parameter logic [21:0] HORN_DIV = 22'd151515,
  parameter logic [21:0] REV_DIV  = 22'd113636,
  parameter logic [21:0] TICK_DIV = 22'd50000,
  parameter int          BEEP_ON  = 25000000,
  parameter int          BEEP_OFF = 25000000,
  parameter int          TICK_LEN = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        horn_req,
  input  logic        rev_req,
  input  logic        turn_req,
  input  logic        turn_blink,
  output logic [21:0] note_div,
  output logic [2:0]  grant,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HORN    = 3'd1,
    REV_ON  = 3'd2,
    REV_OFF = 3'd3,
    TICK    = 3'd4
  } state_t;

  // Terminal timer values: a timed state leaves on the edge where the timer
  // holds its length minus one, giving exactly "length" cycles in the state.
  localparam logic [24:0] ON_LAST   = 25'(BEEP_ON - 1);
  localparam logic [24:0] OFF_LAST  = 25'(BEEP_OFF - 1);
  localparam logic [24:0] TICK_LAST = 25'(TICK_LEN - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [24:0] r_timer;
  logic [21:0] r_note_div;
  logic [1:0]  r_grant_lo;
  logic        r_busy;
  logic        w_tick_pend;

  // Next-state logic.  Horn overrides everything; otherwise each state decides.
  always_comb begin
    w_state_next = r_state;
    if (horn_req) begin
      w_state_next = HORN;
    end else begin
      case (r_state)
        IDLE: begin
          if (rev_req)          w_state_next = REV_ON;
          else if (w_tick_pend) w_state_next = TICK;
        end
        HORN: begin
          if (rev_req)          w_state_next = REV_ON;
          else if (w_tick_pend) w_state_next = TICK;
          else                  w_state_next = IDLE;
        end
        REV_ON: begin
          if (!rev_req)              w_state_next = w_tick_pend ? TICK : IDLE;
          else if (r_timer == ON_LAST) w_state_next = REV_OFF;
        end
        REV_OFF: begin
          if (!rev_req)               w_state_next = w_tick_pend ? TICK : IDLE;
          else if (r_timer == OFF_LAST) w_state_next = REV_ON;
        end
        TICK: begin
          if (r_timer == TICK_LAST) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State, timer and outputs.  Outputs are decoded from the next state so they
  // change on the same edge as the state register (Moore, registered).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_note_div <= '0;
      r_grant_lo <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Any state change, including REV_ON <-> REV_OFF, restarts the timer.
      r_timer <= (w_state_next != r_state) ? 25'd0 : r_timer + 25'd1;
      r_busy  <= (w_state_next != IDLE);
      case (w_state_next)
        HORN: begin
          r_note_div <= HORN_DIV;
          r_grant_lo <= 2'b01;
        end
        REV_ON: begin
          r_note_div <= REV_DIV;
          r_grant_lo <= 2'b10;
        end
        REV_OFF: begin
          r_note_div <= '0;
          r_grant_lo <= 2'b10;
        end
        TICK: begin
          r_note_div <= TICK_DIV;
          r_grant_lo <= 2'b00;
        end
        default: begin
          r_note_div <= '0;
          r_grant_lo <= 2'b00;
        end
      endcase
    end
  end

`ifdef BUZZER_TICK_EN
  logic r_tick_pending;
  logic r_grant_tick;

  assign w_tick_pend = r_tick_pending;

  // A blink is only remembered while the turn signal is on; one arriving
  // during a tick is dropped, and the flag is consumed when the tick starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_pending <= 1'b0;
      r_grant_tick   <= 1'b0;
    end else begin
      if (!turn_req)
        r_tick_pending <= 1'b0;
      else if (w_state_next == TICK && r_state != TICK)
        r_tick_pending <= 1'b0;
      else if (turn_blink && r_state != TICK)
        r_tick_pending <= 1'b1;
      r_grant_tick <= (w_state_next == TICK);
    end
  end

  assign grant = {r_grant_tick, r_grant_lo};
`else
  logic w_unused;

  assign w_tick_pend = 1'b0;
  assign w_unused    = &{1'b0, turn_req, turn_blink};
  assign grant       = {1'b0, r_grant_lo};
`endif

  assign note_div = r_note_div;
  assign busy     = r_busy;

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 The block SHALL have parameter HORN_DIV, default 22'd151515: the horn tone divider.
REQ-002 The block SHALL have parameter REV_DIV, default 22'd113636: the reverse-beep tone divider.
REQ-003 The block SHALL have parameter TICK_DIV, default 22'd50000: the turn-tick tone divider.
REQ-004 The block SHALL have parameter BEEP_ON, default 25000000: reverse-beep tone length in cycles, range 1..2^25-1.
REQ-005 The block SHALL have parameter BEEP_OFF, default 25000000: reverse-beep silence length in cycles, range 1..2^25-1.
REQ-006 The block SHALL have parameter TICK_LEN, default 2000000: turn-tick length in cycles, range 1..2^25-1.
REQ-007 The block SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port horn_req, input, 1 bit: level, horn key held.
REQ-010 The block SHALL have port rev_req, input, 1 bit: level, reverse gear engaged.
REQ-011 The block SHALL have port turn_req, input, 1 bit: level, a turn signal active.
REQ-012 The block SHALL have port turn_blink, input, 1 bit: single-cycle pulse on each blinker toggle.
REQ-013 The block SHALL have port note_div, output, 22 bits: the divider driven to the shared buzzer generator, where 0 means silent.
REQ-014 The block SHALL have port grant, output, 3 bits: one-hot owner, {tick, rev, horn}, with 0 when idle.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever grant is not 0.

Function
REQ-016 The FSM SHALL have the states IDLE, HORN, REV_ON, REV_OFF and TICK, held in a single state register.
REQ-017 The outputs SHALL be a Moore decode of the state: HORN gives HORN_DIV with grant 001; REV_ON gives REV_DIV with grant 010; REV_OFF gives 0 with grant 010; TICK gives TICK_DIV with grant 100; IDLE gives 0 with grant 000.
REQ-018 The fixed priority SHALL be horn, then rev, then tick; inputs SHALL be sampled on each rising clk edge.
REQ-019 A horn_req high at edge k SHALL enter HORN at edge k, from any state, and SHALL hold there while horn_req stays high.
REQ-020 When horn_req is low in HORN: rev_req high SHALL enter REV_ON with a fresh timer; else a pending tick SHALL enter TICK; else the FSM SHALL enter IDLE.
REQ-021 IDLE with rev_req high and horn_req low SHALL enter REV_ON.
REQ-022 REV_ON SHALL last exactly BEEP_ON cycles and then enter REV_OFF.
REQ-023 REV_OFF SHALL last exactly BEEP_OFF cycles and then enter REV_ON.
REQ-024 rev_req low in REV_ON or REV_OFF SHALL cause exit on the next edge, to TICK if a tick is pending, else to IDLE.
REQ-025 A 25-bit timer SHALL clear on every state entry, and a timed state SHALL exit on the edge where the timer equals its length minus 1.
REQ-026 A tick_pending flag SHALL set on turn_blink while turn_req is high and the FSM is not in TICK.
REQ-027 tick_pending SHALL clear on entry to TICK or whenever turn_req is low; a turn_blink pulse that arrives during TICK SHALL be dropped.
REQ-028 IDLE with tick_pending set and no horn or rev request SHALL enter TICK; TICK SHALL last TICK_LEN cycles and then enter IDLE.
REQ-029 A horn preempting TICK SHALL abandon the tick and SHALL NOT re-queue it.
REQ-030 When horn_req and rev_req rise in the same cycle, HORN SHALL win.

Reset
REQ-031 While rst is high, the block SHALL hold state IDLE, timer 0, tick_pending 0, note_div 0, grant 0 and busy 0, independent of clk.
REQ-032 Reset asserted mid-beep SHALL silence note_div immediately; after release the block SHALL restart from IDLE.

Configuration
REQ-033 With macro BUZZER_TICK_EN defined, the tick path (tick_pending and TICK) SHALL be compiled in.
REQ-034 Without BUZZER_TICK_EN, turn_req and turn_blink SHALL be ignored, TICK SHALL be unreachable, and grant[2] SHALL be tied to 0.

Verification (BEEP_ON=4, BEEP_OFF=3, TICK_LEN=2)
REQ-035 rev_req held high from IDLE -> note_div SHALL repeat REV_DIV for 4 cycles, then 0 for 3 cycles, and grant SHALL stay 010 throughout.
REQ-036 horn_req pulsed for 5 cycles during REV_OFF -> note_div SHALL be HORN_DIV for 5 cycles, then REV_DIV for 4 cycles with a fresh timer.
REQ-037 turn_req high with one turn_blink pulse, otherwise idle -> note_div SHALL be TICK_DIV for 2 cycles with grant 100, then return to 0.
REQ-038 turn_blink during rev beeping, then rev_req dropped -> TICK SHALL follow directly; if turn_req falls first, no tick SHALL follow.
REQ-039 rst asserted asynchronously in REV_ON -> note_div and grant SHALL be 0 before the next clk edge.
REQ-040 Build without BUZZER_TICK_EN and pulse turn_blink -> note_div SHALL stay 0 and grant SHALL stay 000.
